// File: rtl/a2bus_event_pkg.sv
// Shared event record and helpers for the Apple II bus event FIFO.
// An event is {rw_n, addr, data}; read events carry a zero data field.
package a2bus_event_pkg;

  localparam int A2BUS_EVENT_W = 25;

  typedef struct packed {
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  data;
  } a2bus_event_t;

  // Value shown on the head outputs straight out of reset.
  localparam a2bus_event_t A2BUS_EVENT_IDLE = '{1'b1, 16'h0000, 8'h00};

  // Upstream never latches read data, so the data field of a read is zeroed.
  function automatic a2bus_event_t make_event(input logic        rw_n,
                                              input logic [15:0] addr,
                                              input logic [7:0]  data);
    a2bus_event_t ev;
    ev.rw_n = rw_n;
    ev.addr = addr;
    ev.data = rw_n ? 8'h00 : data;
    return ev;
  endfunction

  function automatic logic addr_match(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/a2bus_event_fifo_if.sv
// Bus-capture side and event-drain side of the event FIFO.
// The FIFO uses the slave modport; the bus front end and card logic use master.
interface a2bus_event_fifo_if;

  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic        rw_n_i;
  logic        data_in_strobe_i;

  logic        ev_valid_o;
  logic        ev_ready_i;
  logic [15:0] ev_addr_o;
  logic [7:0]  ev_data_o;
  logic        ev_rw_n_o;

  modport slave (
    input  addr_i,
    input  data_i,
    input  rw_n_i,
    input  data_in_strobe_i,
    input  ev_ready_i,
    output ev_valid_o,
    output ev_addr_o,
    output ev_data_o,
    output ev_rw_n_o
  );

  modport master (
    output addr_i,
    output data_i,
    output rw_n_i,
    output data_in_strobe_i,
    output ev_ready_i,
    input  ev_valid_o,
    input  ev_addr_o,
    input  ev_data_o,
    input  ev_rw_n_o
  );

endinterface

// File: rtl/a2bus_event_ram.sv
// DEPTH x 25-bit simple dual-port event storage: one write port, one registered read port.
// The read register doubles as the FIFO head, hence its reset to the idle event.
module a2bus_event_ram
  import a2bus_event_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  a2bus_event_t             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output a2bus_event_t             rdata
);

  a2bus_event_t mem [DEPTH];
  a2bus_event_t rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= A2BUS_EVENT_IDLE;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/a2bus_event_fifo.sv
// Filters qualified Apple II bus cycles by address window and queues them in a
// first-word-fall-through FIFO whose head is the RAM's registered read port.
module a2bus_event_fifo
  import a2bus_event_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_BASE     = 16'hC000,
  parameter logic [15:0] ADDR_MASK     = 16'hFF00,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                   clk_logic_i,
  input  logic                   system_reset_n_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  a2bus_event_fifo_if.slave      bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [7:0]             drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          head_valid_reg;
  logic          overflow_reg;
  logic [7:0]    drop_count_reg;

  logic          match;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic          ram_pending;
  logic          load_head;
  a2bus_event_t  wr_event;
  a2bus_event_t  head;

  // count_reg includes the head; anything beyond it still sits in RAM
  // waiting to be read into the head register.
  always_comb begin
    match       = addr_match(bus.addr_i, ADDR_BASE, ADDR_MASK);
    push_req    = enable_i && bus.data_in_strobe_i && match
                  && (!bus.rw_n_i || CAPTURE_READS);
    pop         = head_valid_reg && bus.ev_ready_i;
    full        = (count_reg == FULL_COUNT);
    push_ok     = push_req && (!full || pop);
    drop        = push_req && !push_ok;
    ram_pending = (count_reg != CW'(head_valid_reg));
    load_head   = ram_pending && (!head_valid_reg || pop) && !clear_i;
    wr_event    = make_event(bus.rw_n_i, bus.addr_i, bus.data_i);
  end

  // Reads and writes never share an address: a write to the read slot would
  // need the RAM empty or holding DEPTH entries, and neither can coincide
  // with load_head.
  a2bus_event_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_logic_i),
    .rst_n (system_reset_n_i),
    .we    (push_ok && !clear_i),
    .waddr (wr_ptr_reg),
    .wdata (wr_event),
    .re    (load_head),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else if (clear_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (load_head) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      if (load_head) begin
        head_valid_reg <= 1'b1;
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF) begin
          drop_count_reg <= drop_count_reg + 8'd1;
        end
      end
    end
  end

  assign bus.ev_valid_o = head_valid_reg;
  assign bus.ev_addr_o  = head.addr;
  assign bus.ev_data_o  = head.data;
  assign bus.ev_rw_n_o  = head.rw_n;

  assign count_o      = count_reg;
  assign overflow_o   = overflow_reg;
  assign drop_count_o = drop_count_reg;

endmodule

// File: tb/tb_a2bus_event_fifo.sv
// Directed bench for a2bus_event_fifo: two instances, one ignoring and one capturing reads.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_a2bus_event_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        enable;
  logic        clear;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;
  logic        strobe;
  logic        strobe_rd;
  logic        ready;
  logic        ready_rd;

  logic [4:0]  count;
  logic [4:0]  count_rd;
  logic        overflow;
  logic        overflow_rd;
  logic [7:0]  drops;
  logic [7:0]  drops_rd;

  a2bus_event_fifo_if bus ();
  a2bus_event_fifo_if bus_rd ();

  assign bus.addr_i              = addr;
  assign bus.data_i              = data;
  assign bus.rw_n_i              = rw_n;
  assign bus.data_in_strobe_i    = strobe;
  assign bus.ev_ready_i          = ready;
  assign bus_rd.addr_i           = addr;
  assign bus_rd.data_i           = data;
  assign bus_rd.rw_n_i           = rw_n;
  assign bus_rd.data_in_strobe_i = strobe_rd;
  assign bus_rd.ev_ready_i       = ready_rd;

  a2bus_event_fifo #(
    .DEPTH         (16),
    .ADDR_BASE     (16'hC000),
    .ADDR_MASK     (16'hFF00),
    .CAPTURE_READS (1'b0)
  ) dut (
    .clk_logic_i      (clk),
    .system_reset_n_i (rst_n),
    .enable_i         (enable),
    .clear_i          (clear),
    .bus              (bus),
    .count_o          (count),
    .overflow_o       (overflow),
    .drop_count_o     (drops)
  );

  a2bus_event_fifo #(
    .DEPTH         (16),
    .ADDR_BASE     (16'hC000),
    .ADDR_MASK     (16'hFF00),
    .CAPTURE_READS (1'b1)
  ) dut_rd (
    .clk_logic_i      (clk),
    .system_reset_n_i (rst_n),
    .enable_i         (enable),
    .clear_i          (clear),
    .bus              (bus_rd),
    .count_o          (count_rd),
    .overflow_o       (overflow_rd),
    .drop_count_o     (drops_rd)
  );

  int check_count = 0;
  int pass_count  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] ev(input logic r, input logic [15:0] a, input logic [7:0] d);
    return {r, a, (r ? 8'h00 : d)};
  endfunction

  function automatic logic [24:0] head_main();
    return {bus.ev_rw_n_o, bus.ev_addr_o, bus.ev_data_o};
  endfunction

  // One clock on the main instance; returns at the following falling edge.
  task automatic cycle(input logic stb, input logic [15:0] a, input logic [7:0] d,
                       input logic rw, input logic rdy);
    strobe = stb;
    addr   = a;
    data   = d;
    rw_n   = rw;
    ready  = rdy;
    if (stb) $display("t=%0t strobe addr=%h data=%h rw_n=%b en=%b clr=%b", $time, a, d, rw, enable, clear);
    if (rdy && bus.ev_valid_o) $display("t=%0t pop    addr=%h data=%h rw_n=%b", $time, bus.ev_addr_o, bus.ev_data_o, bus.ev_rw_n_o);
    @(negedge clk);
    strobe = 1'b0;
    ready  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic [24:0] q[$];
    logic [24:0] exp_ev;
    int          ev_n;

    enable = 1'b1; clear = 1'b0; addr = 16'h0000; data = 8'h00; rw_n = 1'b1;
    strobe = 1'b0; strobe_rd = 1'b0; ready = 1'b0; ready_rd = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.ev_valid_o), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_drops", 32'(drops), 32'h0);
    check("rst_addr", 32'(bus.ev_addr_o), 32'h0);
    check("rst_data", 32'(bus.ev_data_o), 32'h0);
    check("rst_rw", 32'(bus.ev_rw_n_o), 32'h1);
    rst_n = 1'b1;
    idle(1);

    // Single in-window write: count after one edge, valid after two
    cycle(1'b1, 16'hC0E3, 8'h5A, 1'b0, 1'b0);
    check("single_count", 32'(count), 32'd1);
    check("single_valid_early", 32'(bus.ev_valid_o), 32'h0);
    idle(1);
    check("single_valid", 32'(bus.ev_valid_o), 32'h1);
    check("single_head", 32'(head_main()), 32'(ev(1'b0, 16'hC0E3, 8'h5A)));
    cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_valid", 32'(bus.ev_valid_o), 32'h0);

    // Capture disabled
    enable = 1'b0;
    cycle(1'b1, 16'hC010, 8'h11, 1'b0, 1'b0);
    enable = 1'b1;
    idle(1);
    check("disabled_count", 32'(count), 32'd0);

    // Filtering: out-of-window write and an ignored read
    cycle(1'b1, 16'h0400, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 16'hC030, 8'hA5, 1'b1, 1'b0);
    idle(2);
    check("filter_count", 32'(count), 32'd0);
    check("filter_valid", 32'(bus.ev_valid_o), 32'h0);

    // Read capture on the second instance: data field forced to zero
    addr = 16'hC030; data = 8'hA5; rw_n = 1'b1; strobe_rd = 1'b1;
    $display("t=%0t strobe_rd addr=%h data=%h rw_n=%b", $time, addr, data, rw_n);
    @(negedge clk);
    strobe_rd = 1'b0;
    check("rd_count", 32'(count_rd), 32'd1);
    @(negedge clk);
    check("rd_valid", 32'(bus_rd.ev_valid_o), 32'h1);
    check("rd_head", 32'({bus_rd.ev_rw_n_o, bus_rd.ev_addr_o, bus_rd.ev_data_o}),
          32'({1'b1, 16'hC030, 8'h00}));
    ready_rd = 1'b1;
    $display("t=%0t pop_rd", $time);
    @(negedge clk);
    ready_rd = 1'b0;
    check("rd_pop_count", 32'(count_rd), 32'd0);

    // Fill and overflow: 18 strobes, last two dropped
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 16'hC080 + 16'(i), 8'(i + 8'h40), 1'b0, 1'b0);
      if (i == 15) check("fill_ovf_before", 32'(overflow), 32'h0);
      if (i == 16) check("fill_drop_first", 32'(drops), 32'd1);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf", 32'(overflow), 32'h1);
    check("fill_drops", 32'(drops), 32'd2);
    check("fill_head", 32'(head_main()), 32'(ev(1'b0, 16'hC080, 8'h40)));

    // Full with simultaneous pop and push: accepted, goes last
    cycle(1'b1, 16'hC0A0, 8'hEE, 1'b0, 1'b1);
    check("fullpp_count", 32'(count), 32'd16);
    check("fullpp_drops", 32'(drops), 32'd2);

    // Back-to-back drain
    for (int i = 0; i < 16; i++) begin
      exp_ev = (i < 15) ? ev(1'b0, 16'hC081 + 16'(i), 8'(i + 8'h41)) : ev(1'b0, 16'hC0A0, 8'hEE);
      check($sformatf("drain_valid_%0d", i), 32'(bus.ev_valid_o), 32'h1);
      check($sformatf("drain_head_%0d", i), 32'(head_main()), 32'(exp_ev));
      cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(bus.ev_valid_o), 32'h0);

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clear_ovf", 32'(overflow), 32'h0);
    check("clear_drops", 32'(drops), 32'd0);

    // Wrap-around: 8 groups of 5 pushes then 5 pops
    ev_n = 0;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) begin
        a = 16'hC000 | 16'((ev_n * 37) & 8'hFF);
        d = 8'(ev_n * 5 + 3);
        q.push_back(ev(1'b0, a, d));
        cycle(1'b1, a, d, 1'b0, 1'b0);
        ev_n++;
      end
      check($sformatf("wrap_count_%0d", g), 32'(count), 32'd5);
      for (int k = 0; k < 5; k++) begin
        exp_ev = q.pop_front();
        check($sformatf("wrap_head_%0d_%0d", g, k), 32'({bus.ev_valid_o, head_main()}), 32'({1'b1, exp_ev}));
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
      end
    end
    check("wrap_drops", 32'(drops), 32'd0);
    check("wrap_count_end", 32'(count), 32'd0);

    // Push and pop together at count 1
    cycle(1'b1, 16'hC0C1, 8'h21, 1'b0, 1'b0);
    idle(1);
    check("one_head", 32'(head_main()), 32'(ev(1'b0, 16'hC0C1, 8'h21)));
    cycle(1'b1, 16'hC0C2, 8'h22, 1'b0, 1'b1);
    check("one_pp_count", 32'(count), 32'd1);
    idle(1);
    check("one_pp_head", 32'({bus.ev_valid_o, head_main()}), 32'({1'b1, ev(1'b0, 16'hC0C2, 8'h22)}));
    cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
    check("one_pp_empty", 32'(count), 32'd0);

    // Clear coincident with a strobe, three entries already queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hC0D0 + 16'(i), 8'(i), 1'b0, 1'b0);
    clear = 1'b1;
    cycle(1'b1, 16'hC0DF, 8'h99, 1'b0, 1'b0);
    clear = 1'b0;
    idle(2);
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(bus.ev_valid_o), 32'h0);

    // Asynchronous reset with 7 entries queued
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'hC0E0 + 16'(i), 8'(8'h80 + i), 1'b0, 1'b0);
    idle(1);
    check("arst_pre_count", 32'(count), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ev_valid_o), 32'h0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovf", 32'(overflow), 32'h0);
    check("arst_drops", 32'(drops), 32'd0);
    check("arst_addr", 32'(bus.ev_addr_o), 32'h0);
    check("arst_data", 32'(bus.ev_data_o), 32'h0);
    check("arst_rw", 32'(bus.ev_rw_n_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("arst_post_count", 32'(count), 32'd0);
    check("arst_post_valid", 32'(bus.ev_valid_o), 32'h0);
    check("rd_inst_ovf", 32'({overflow_rd, drops_rd}), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
